// File: rtl/pcss_run_ctrl.sv
// +--------------------------------------------------------------------------+
// | pcss_run_ctrl: sequences config load, settle wait, tik-paced spike frames |
// | and completion wait onto the pcss_inf send channel.   Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pcss_run_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int TIK_CNT_W  = 8,
  parameter int CFG_WAIT   = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             cfg_len,
  input  logic [TIK_CNT_W-1:0]    num_tiks,
  input  logic [DATA_WIDTH-1:0]   s_cfg_tdata,
  input  logic                    s_cfg_tvalid,
  output logic                    s_cfg_tready,
  input  logic [DATA_WIDTH-1:0]   s_spk_tdata,
  input  logic                    s_spk_tvalid,
  input  logic                    s_spk_tlast,
  output logic                    s_spk_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  input  logic                    m_tready,
  input  logic [DATA_WIDTH-1:0]   r_tdata,
  input  logic                    r_tvalid,
  input  logic                    tik,
  output logic                    busy,
  output logic                    done,
  output logic                    err_late,
  output logic [TIK_CNT_W-1:0]    tik_cnt,
  output logic [2:0]              state_o
);

  localparam int WAIT_W = (CFG_WAIT > 1) ? $clog2(CFG_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CFG_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG       = 3'd1,
    ST_CFG_WAIT  = 3'd2,
    ST_SPK       = 3'd3,
    ST_WAIT_TIK  = 3'd4,
    ST_DONE_WAIT = 3'd5
  } state_t;

  state_t                 state;
  logic [31:0]            cfg_len_q;
  logic [31:0]            beat_cnt;
  logic [TIK_CNT_W-1:0]   num_tiks_q;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   pending;
  logic                   tik_dly;

  logic                   tik_fall;
  logic                   cfg_last;
  logic [TIK_CNT_W-1:0]   tik_next;

  assign tik_fall = tik_dly & ~tik;
  assign cfg_last = (beat_cnt == cfg_len_q - 32'd1);
  assign tik_next = tik_cnt + TIK_CNT_W'(1);

  assign m_tkeep = '1;
  assign busy    = (state != ST_IDLE);
  assign state_o = state;

  // Zero-latency passthrough selected by the registered state.
  always_comb begin
    m_tdata      = '0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    s_cfg_tready = 1'b0;
    s_spk_tready = 1'b0;
    case (state)
      ST_CFG: begin
        m_tdata      = s_cfg_tdata;
        m_tvalid     = s_cfg_tvalid;
        m_tlast      = cfg_last;
        s_cfg_tready = m_tready;
      end
      ST_SPK: begin
        m_tdata      = s_spk_tdata;
        m_tvalid     = s_spk_tvalid;
        m_tlast      = s_spk_tlast;
        s_spk_tready = m_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cfg_len_q  <= '0;
      beat_cnt   <= '0;
      num_tiks_q <= '0;
      wait_cnt   <= '0;
      pending    <= 1'b0;
      tik_dly    <= 1'b0;
      tik_cnt    <= '0;
      err_late   <= 1'b0;
      done       <= 1'b0;
    end else begin
      tik_dly <= tik;
      done    <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cfg_len_q  <= cfg_len;
              num_tiks_q <= num_tiks;
              tik_cnt    <= '0;
              err_late   <= 1'b0;
              beat_cnt   <= '0;
              pending    <= 1'b0;
              wait_cnt   <= WAIT_LOAD;
              state      <= (cfg_len != 32'd0) ? ST_CFG : ST_CFG_WAIT;
            end
          end
          ST_CFG: begin
            if (s_cfg_tvalid && m_tready) begin
              beat_cnt <= beat_cnt + 32'd1;
              if (cfg_last) begin
                wait_cnt <= WAIT_LOAD;
                state    <= ST_CFG_WAIT;
              end
            end
          end
          ST_CFG_WAIT: begin
            if (wait_cnt == '0)
              state <= (num_tiks_q != '0) ? ST_SPK : ST_DONE_WAIT;
            else
              wait_cnt <= wait_cnt - WAIT_W'(1);
          end
          ST_SPK: begin
            if (s_spk_tvalid && m_tready && s_spk_tlast)
              state <= ST_WAIT_TIK;
          end
          ST_WAIT_TIK: begin
            // An edge that arrived early is consumed here without waiting.
            if (tik_fall || pending) begin
              tik_cnt <= tik_next;
              pending <= 1'b0;
              state   <= (tik_next == num_tiks_q) ? ST_DONE_WAIT : ST_SPK;
            end
          end
          ST_DONE_WAIT: begin
            if (r_tvalid && (r_tdata == {DATA_WIDTH{1'b1}})) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      if (tik_fall && (state != ST_IDLE) && (state != ST_WAIT_TIK)) begin
        err_late <= 1'b1;
        pending  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcss_run_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pcss_run_ctrl: directed self-checking bench for pcss_run_ctrl.         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pcss_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [31:0] cfg_len;
  logic [7:0]  num_tiks;
  logic [63:0] s_cfg_tdata;
  logic        s_cfg_tvalid, s_cfg_tready;
  logic [63:0] s_spk_tdata;
  logic        s_spk_tvalid, s_spk_tlast, s_spk_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic [7:0]  m_tkeep;
  logic        m_tready;
  logic [63:0] r_tdata;
  logic        r_tvalid;
  logic        tik;
  logic        busy, done, err_late;
  logic [7:0]  tik_cnt;
  logic [2:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pcss_run_ctrl #(.DATA_WIDTH(64), .TIK_CNT_W(8), .CFG_WAIT(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_len(cfg_len), .num_tiks(num_tiks),
    .s_cfg_tdata(s_cfg_tdata), .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready),
    .s_spk_tdata(s_spk_tdata), .s_spk_tvalid(s_spk_tvalid), .s_spk_tlast(s_spk_tlast),
    .s_spk_tready(s_spk_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
    .m_tready(m_tready), .r_tdata(r_tdata), .r_tvalid(r_tvalid), .tik(tik),
    .busy(busy), .done(done), .err_late(err_late), .tik_cnt(tik_cnt), .state_o(state_o)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Falling edge of tik is detected in the cycle after it drops.
  task automatic tik_pulse;
    tik = 1'b1;
    step;
    tik = 1'b0;
    step;
  endtask

  task automatic launch(input logic [31:0] len, input logic [7:0] nt);
    start = 1'b1; cfg_len = len; num_tiks = nt;
    step;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++; if (state_o !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_o); end
    n_cmp++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_m: got v=%b l=%b want 0 0", m_tvalid, m_tlast); end
    n_cmp++; if (s_cfg_tready !== 1'b0 || s_spk_tready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b %b want 0 0", s_cfg_tready, s_spk_tready); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err_late !== 1'b0) begin n_err++; $display("FAIL rst_flags: got b=%b d=%b e=%b want 0", busy, done, err_late); end
    n_cmp++; if (tik_cnt !== 8'd0 || m_tdata !== 64'd0) begin n_err++; $display("FAIL rst_cnt_data: got %0d %h want 0 0", tik_cnt, m_tdata); end
    n_cmp++; if (m_tkeep !== 8'hFF) begin n_err++; $display("FAIL rst_keep: got %h want ff", m_tkeep); end
    @(negedge clk);
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_basic;
    int gap;
    launch(32'd4, 8'd2);
    n_cmp++; if (state_o !== 3'd1 || busy !== 1'b1) begin n_err++; $display("FAIL basic_cfg_entry: got st=%0d busy=%b want 1 1", state_o, busy); end
    for (int k = 0; k < 4; k++) begin
      s_cfg_tvalid = 1'b1; s_cfg_tdata = 64'hA000 + 64'(k); #1;
      n_cmp++; if (m_tdata !== 64'hA000 + 64'(k) || m_tvalid !== 1'b1) begin n_err++; $display("FAIL basic_cfg_data[%0d]: got %h v=%b want %h v=1", k, m_tdata, m_tvalid, 64'hA000 + 64'(k)); end
      n_cmp++; if (m_tlast !== (k == 3) || s_cfg_tready !== 1'b1 || s_spk_tready !== 1'b0) begin n_err++; $display("FAIL basic_cfg_ctl[%0d]: got last=%b cr=%b sr=%b want %b 1 0", k, m_tlast, s_cfg_tready, s_spk_tready, (k == 3)); end
      step;
    end
    s_cfg_tvalid = 1'b0;
    s_spk_tvalid = 1'b1; s_spk_tdata = 64'hB000; s_spk_tlast = 1'b0; #1;
    gap = 0;
    while (m_tvalid == 1'b0 && gap < 200) begin gap++; step; end
    n_cmp++; if (gap !== 100) begin n_err++; $display("FAIL basic_gap: got %0d want 100", gap); end
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++) begin
        s_spk_tvalid = 1'b1; s_spk_tdata = 64'hB000 + 64'(16 * f + b); s_spk_tlast = (b == 2); #1;
        n_cmp++; if (state_o !== 3'd3 || m_tdata !== 64'hB000 + 64'(16 * f + b) || m_tlast !== (b == 2)) begin n_err++; $display("FAIL basic_spk[%0d.%0d]: got st=%0d d=%h l=%b want 3 %h %b", f, b, state_o, m_tdata, m_tlast, 64'hB000 + 64'(16 * f + b), (b == 2)); end
        step;
      end
      s_spk_tvalid = 1'b0; s_spk_tlast = 1'b0; #1;
      n_cmp++; if (state_o !== 3'd4 || m_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_wait_tik[%0d]: got st=%0d v=%b want 4 0", f, state_o, m_tvalid); end
      tik_pulse;
      n_cmp++; if (tik_cnt !== 8'(f + 1)) begin n_err++; $display("FAIL basic_tik_cnt[%0d]: got %0d want %0d", f, tik_cnt, f + 1); end
      n_cmp++; if (state_o !== (f == 0 ? 3'd3 : 3'd5)) begin n_err++; $display("FAIL basic_after_tik[%0d]: got %0d want %0d", f, state_o, (f == 0 ? 3 : 5)); end
    end
    n_cmp++; if (err_late !== 1'b0) begin n_err++; $display("FAIL basic_err_late: got %b want 0", err_late); end
    r_tvalid = 1'b1; r_tdata = '1;
    step;
    r_tvalid = 1'b0; r_tdata = '0;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || state_o !== 3'd0) begin n_err++; $display("FAIL basic_done: got d=%b b=%b st=%0d want 1 0 0", done, busy, state_o); end
    step;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_backpressure;
    logic [15:0] pat;
    int idx, cyc;
    pat = 16'b1011_0010_1101_0110;
    launch(32'd5, 8'd1);
    idx = 0; cyc = 0;
    while (idx < 5 && cyc < 40) begin
      s_cfg_tvalid = 1'b1; s_cfg_tdata = 64'hC0 + 64'(idx); m_tready = pat[cyc % 16]; #1;
      n_cmp++; if (s_cfg_tready !== m_tready || s_spk_tready !== 1'b0) begin n_err++; $display("FAIL bp_cfg_ready[%0d]: got cr=%b sr=%b want %b 0", cyc, s_cfg_tready, s_spk_tready, m_tready); end
      n_cmp++; if (m_tdata !== 64'hC0 + 64'(idx) || m_tlast !== (idx == 4)) begin n_err++; $display("FAIL bp_cfg_beat[%0d]: got %h l=%b want %h %b", idx, m_tdata, m_tlast, 64'hC0 + 64'(idx), (idx == 4)); end
      if (m_tready) idx++;
      cyc++;
      step;
    end
    s_cfg_tvalid = 1'b0; m_tready = 1'b1; #1;
    n_cmp++; if (idx !== 5 || state_o !== 3'd2) begin n_err++; $display("FAIL bp_cfg_count: got beats=%0d st=%0d want 5 2", idx, state_o); end
    for (int i = 0; i < 150 && state_o != 3'd3; i++) step;
    n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL bp_reach_spk: got %0d want 3", state_o); end
    idx = 0;
    while (idx < 4 && cyc < 80) begin
      s_spk_tvalid = 1'b1; s_spk_tdata = 64'h50 + 64'(idx); s_spk_tlast = (idx == 3); m_tready = pat[cyc % 16]; #1;
      n_cmp++; if (s_spk_tready !== m_tready || s_cfg_tready !== 1'b0) begin n_err++; $display("FAIL bp_spk_ready[%0d]: got sr=%b cr=%b want %b 0", cyc, s_spk_tready, s_cfg_tready, m_tready); end
      n_cmp++; if (m_tdata !== 64'h50 + 64'(idx) || state_o !== 3'd3) begin n_err++; $display("FAIL bp_spk_beat[%0d]: got %h st=%0d want %h 3", idx, m_tdata, state_o, 64'h50 + 64'(idx)); end
      if (m_tready) idx++;
      cyc++;
      step;
    end
    s_spk_tvalid = 1'b0; s_spk_tlast = 1'b0; m_tready = 1'b1; #1;
    n_cmp++; if (idx !== 4 || state_o !== 3'd4) begin n_err++; $display("FAIL bp_spk_count: got beats=%0d st=%0d want 4 4", idx, state_o); end
    tik_pulse;
    n_cmp++; if (tik_cnt !== 8'd1 || state_o !== 3'd5) begin n_err++; $display("FAIL bp_tik: got cnt=%0d st=%0d want 1 5", tik_cnt, state_o); end
    r_tvalid = 1'b1; r_tdata = '1;
    step;
    r_tvalid = 1'b0; r_tdata = '0;
    n_cmp++; if (done !== 1'b1 || state_o !== 3'd0) begin n_err++; $display("FAIL bp_done: got d=%b st=%0d want 1 0", done, state_o); end
  endtask

  task automatic test_late_tik;
    launch(32'd0, 8'd2);
    n_cmp++; if (state_o !== 3'd2) begin n_err++; $display("FAIL late_cfg0_skip: got %0d want 2", state_o); end
    for (int i = 0; i < 150 && state_o != 3'd3; i++) step;
    n_cmp++; if (state_o !== 3'd3) begin n_err++; $display("FAIL late_reach_spk: got %0d want 3", state_o); end
    tik_pulse;
    n_cmp++; if (err_late !== 1'b1 || state_o !== 3'd3 || tik_cnt !== 8'd0) begin n_err++; $display("FAIL late_flag: got e=%b st=%0d cnt=%0d want 1 3 0", err_late, state_o, tik_cnt); end
    s_spk_tvalid = 1'b1; s_spk_tdata = 64'hD1; s_spk_tlast = 1'b1;
    step;
    s_spk_tvalid = 1'b0; s_spk_tlast = 1'b0; #1;
    n_cmp++; if (state_o !== 3'd4 || m_tvalid !== 1'b0) begin n_err++; $display("FAIL late_wait_entry: got st=%0d v=%b want 4 0", state_o, m_tvalid); end
    step;
    n_cmp++; if (state_o !== 3'd3 || tik_cnt !== 8'd1) begin n_err++; $display("FAIL late_pending_exit: got st=%0d cnt=%0d want 3 1", state_o, tik_cnt); end
    s_spk_tvalid = 1'b1; s_spk_tdata = 64'hD2; #1;
    n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL abort_pre_valid: got %b want 1", m_tvalid); end
    abort = 1'b1;
    step;
    abort = 1'b0; #1;
    n_cmp++; if (state_o !== 3'd0 || m_tvalid !== 1'b0) begin n_err++; $display("FAIL abort_idle: got st=%0d v=%b want 0 0", state_o, m_tvalid); end
    n_cmp++; if (err_late !== 1'b1 || tik_cnt !== 8'd1) begin n_err++; $display("FAIL abort_hold: got e=%b cnt=%0d want 1 1", err_late, tik_cnt); end
    s_spk_tvalid = 1'b0;
  endtask

  task automatic test_edge_cases;
    launch(32'd1, 8'd0);
    n_cmp++; if (state_o !== 3'd1 || err_late !== 1'b0 || tik_cnt !== 8'd0) begin n_err++; $display("FAIL edge_start_clear: got st=%0d e=%b cnt=%0d want 1 0 0", state_o, err_late, tik_cnt); end
    s_cfg_tvalid = 1'b1; s_cfg_tdata = 64'hAA; #1;
    n_cmp++; if (m_tlast !== 1'b1) begin n_err++; $display("FAIL edge_single_last: got %b want 1", m_tlast); end
    step;
    s_cfg_tvalid = 1'b0;
    launch(32'd7, 8'd3);
    n_cmp++; if (state_o !== 3'd2 || busy !== 1'b1) begin n_err++; $display("FAIL edge_start_busy: got st=%0d b=%b want 2 1", state_o, busy); end
    for (int i = 0; i < 150 && state_o == 3'd2; i++) step;
    n_cmp++; if (state_o !== 3'd5) begin n_err++; $display("FAIL edge_ntik0: got %0d want 5", state_o); end
    r_tvalid = 1'b0; r_tdata = '1;
    step;
    n_cmp++; if (done !== 1'b0 || state_o !== 3'd5) begin n_err++; $display("FAIL filter_novalid: got d=%b st=%0d want 0 5", done, state_o); end
    r_tvalid = 1'b1; r_tdata = 64'h0123_4567_89AB_CDEF;
    step;
    n_cmp++; if (done !== 1'b0 || state_o !== 3'd5) begin n_err++; $display("FAIL filter_word: got d=%b st=%0d want 0 5", done, state_o); end
    r_tdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step;
    r_tvalid = 1'b0; r_tdata = '0;
    n_cmp++; if (done !== 1'b1 || state_o !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL filter_ones: got d=%b st=%0d b=%b want 1 0 0", done, state_o, busy); end
    step;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL filter_pulse: got %b want 0", done); end
  endtask

  task automatic test_async_reset;
    launch(32'd3, 8'd1);
    tik_pulse;
    n_cmp++; if (err_late !== 1'b1 || state_o !== 3'd1) begin n_err++; $display("FAIL ar_cfg_late: got e=%b st=%0d want 1 1", err_late, state_o); end
    s_cfg_tvalid = 1'b1; s_cfg_tdata = 64'h77; #1;
    n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h77) begin n_err++; $display("FAIL ar_pre: got v=%b d=%h want 1 77", m_tvalid, m_tdata); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (state_o !== 3'd0 || busy !== 1'b0 || m_tvalid !== 1'b0) begin n_err++; $display("FAIL ar_state: got st=%0d b=%b v=%b want 0 0 0", state_o, busy, m_tvalid); end
    n_cmp++; if (m_tdata !== 64'd0 || s_cfg_tready !== 1'b0 || m_tlast !== 1'b0) begin n_err++; $display("FAIL ar_path: got d=%h cr=%b l=%b want 0 0 0", m_tdata, s_cfg_tready, m_tlast); end
    n_cmp++; if (err_late !== 1'b0 || tik_cnt !== 8'd0 || done !== 1'b0 || m_tkeep !== 8'hFF) begin n_err++; $display("FAIL ar_regs: got e=%b cnt=%0d d=%b k=%h want 0 0 0 ff", err_late, tik_cnt, done, m_tkeep); end
    s_cfg_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_len = '0; num_tiks = '0;
    s_cfg_tdata = '0; s_cfg_tvalid = 1'b0;
    s_spk_tdata = '0; s_spk_tvalid = 1'b0; s_spk_tlast = 1'b0;
    m_tready = 1'b1; r_tdata = '0; r_tvalid = 1'b0; tik = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_late_tik;
    test_edge_cases;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
